hpdcache_refill_fifo_ft: RTL and testbench

- Parametrised refill-response FIFO between the HPDcache refill handler and the core response path.
- Generalises the fixed-depth refill FIFO:
  - any depth, including non-power-of-two;
  - any payload width;
  - optional empty-bypass (feedthrough) mode;
  - programmable almost-full threshold;
  - occupancy output;
  - synchronous flush.
- The refill handler uses afull_o to throttle new MSHR refills before the FIFO saturates.

---
 rtl/hpdcache_refill_fifo_ft.sv | 153 +++++++++++++++
 tb/tb_hpdcache_refill_fifo_ft.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_refill_fifo_ft.sv
// hpdcache_refill_fifo_ft
// Refill-response FIFO between the HPDcache refill handler and the core response path.
// Supports any depth (including non-power-of-two) and any payload width. It also offers
// an optional empty bypass (FEEDTHROUGH), a programmable almost-full threshold, an
// occupancy output and a synchronous flush.
// Optional peak-occupancy monitor: define HPDCACHE_REFILL_FIFO_PEAK_OCC_EN to add
// peak_clr_i / peak_occ_o.
module hpdcache_refill_fifo_ft #(
  parameter int unsigned  DEPTH        = 2,
  parameter int unsigned  DATA_WIDTH   = 64,
  parameter bit           FEEDTHROUGH  = 1'b1,
  parameter int unsigned  AFULL_THRESH = DEPTH - 1,
  localparam int unsigned CW           = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
`ifdef HPDCACHE_REFILL_FIFO_PEAK_OCC_EN
  input  logic                  peak_clr_i,
  output logic [CW-1:0]         peak_occ_o,
`endif
  input  logic                  w_i,
  output logic                  wok_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  r_i,
  output logic                  rok_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [CW-1:0]         occ_o,
  output logic                  afull_o
);

  localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] OccFull  = CW'(DEPTH);
  localparam logic [CW-1:0] OccAfull = CW'(AFULL_THRESH);
  localparam logic [PW-1:0] PtrLast  = PW'(DEPTH - 1);

  // Elaboration-time parameter legality checks.
  if (DEPTH == 0 || DEPTH > 256) begin : g_err_depth
    $error("hpdcache_refill_fifo_ft: DEPTH must be in 1..256");
  end
  if (AFULL_THRESH == 0 || AFULL_THRESH > DEPTH) begin : g_err_afull
    $error("hpdcache_refill_fifo_ft: AFULL_THRESH must be in 1..DEPTH");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_rptr;
  logic [PW-1:0]         r_wptr;
  logic [CW-1:0]         r_occ;

  logic [PW-1:0]         w_rptr_next;
  logic [PW-1:0]         w_wptr_next;
  logic [CW-1:0]         w_occ_next;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_bypass;
  logic                  w_store;
  logic                  w_fetch;
  logic [DATA_WIDTH-1:0] w_head;

  assign w_empty = (r_occ == '0);
  assign w_full  = (r_occ == OccFull);
  assign w_head  = r_mem[r_rptr];

  // wok_o depends on registered state and flush only, never on r_i: a full FIFO
  // refuses writes even when a pop happens in the same cycle.
  assign wok_o = ~w_full & ~flush_i;

  if (FEEDTHROUGH) begin : g_feedthrough
    // When empty, the incoming write is presented directly at the read side.
    assign rok_o    = (~w_empty | w_i) & ~flush_i;
    assign rdata_o  = w_empty ? wdata_i : w_head;
    assign w_bypass = w_empty & w_push & w_pop;
  end else begin : g_registered
    assign rok_o    = ~w_empty & ~flush_i;
    assign rdata_o  = w_head;
    assign w_bypass = 1'b0;
  end

  assign w_push = w_i & wok_o;
  assign w_pop  = r_i & rok_o;

  // A bypassed beat never touches storage, pointers or occupancy.
  assign w_store = w_push & ~w_bypass;
  assign w_fetch = w_pop & ~w_bypass;

  assign occ_o   = r_occ;
  assign afull_o = (r_occ >= OccAfull);

  // Next-state for pointers and occupancy; flush has priority over push/pop.
  always_comb begin
    w_rptr_next = r_rptr;
    w_wptr_next = r_wptr;
    w_occ_next  = r_occ;
    if (flush_i) begin
      w_rptr_next = '0;
      w_wptr_next = '0;
      w_occ_next  = '0;
    end else begin
      // Explicit wrap compare so non-power-of-two depths work.
      if (w_store) begin
        w_wptr_next = (r_wptr == PtrLast) ? '0 : r_wptr + PW'(1);
      end
      if (w_fetch) begin
        w_rptr_next = (r_rptr == PtrLast) ? '0 : r_rptr + PW'(1);
      end
      case ({w_store, w_fetch})
        2'b10:   w_occ_next = r_occ + CW'(1);
        2'b01:   w_occ_next = r_occ - CW'(1);
        default: w_occ_next = r_occ;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_occ  <= '0;
    end else begin
      r_rptr <= w_rptr_next;
      r_wptr <= w_wptr_next;
      r_occ  <= w_occ_next;
    end
  end

  // Storage array write; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (w_store) begin
      r_mem[r_wptr] <= wdata_i;
    end
  end

`ifdef HPDCACHE_REFILL_FIFO_PEAK_OCC_EN
  logic [CW-1:0] r_peak;

  // High-water mark of occupancy; a clear restarts it from the upcoming occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_peak <= '0;
    end else if (peak_clr_i) begin
      r_peak <= w_occ_next;
    end else if (w_occ_next > r_peak) begin
      r_peak <= w_occ_next;
    end
  end

  assign peak_occ_o = r_peak;
`endif

endmodule

// File: tb/tb_hpdcache_refill_fifo_ft.sv
// Self-checking bench for hpdcache_refill_fifo_ft.
// Instance A: DEPTH=3, AFULL_THRESH=2, FEEDTHROUGH=0 (non-power-of-two, registered).
// Instance B: DEPTH=2, default AFULL_THRESH (1), FEEDTHROUGH=1 (bypass).
// Peak-occupancy checks are compiled in when HPDCACHE_REFILL_FIFO_PEAK_OCC_EN is defined.
module tb_hpdcache_refill_fifo_ft;

  logic       clk;
  logic       rst_n;

  logic       a_fl, a_w, a_r, a_wok, a_rok, a_afull;
  logic [7:0] a_d, a_rdata;
  logic [1:0] a_occ;

  logic       b_fl, b_w, b_r, b_wok, b_rok, b_afull;
  logic [7:0] b_d, b_rdata;
  logic [1:0] b_occ;

`ifdef HPDCACHE_REFILL_FIFO_PEAK_OCC_EN
  logic       a_pk_clr, b_pk_clr;
  logic [1:0] a_peak, b_peak;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  hpdcache_refill_fifo_ft #(
    .DEPTH       (3),
    .DATA_WIDTH  (8),
    .FEEDTHROUGH (1'b0),
    .AFULL_THRESH(2)
  ) dut_a (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .flush_i   (a_fl),
`ifdef HPDCACHE_REFILL_FIFO_PEAK_OCC_EN
    .peak_clr_i(a_pk_clr),
    .peak_occ_o(a_peak),
`endif
    .w_i       (a_w),
    .wok_o     (a_wok),
    .wdata_i   (a_d),
    .r_i       (a_r),
    .rok_o     (a_rok),
    .rdata_o   (a_rdata),
    .occ_o     (a_occ),
    .afull_o   (a_afull)
  );

  hpdcache_refill_fifo_ft #(
    .DEPTH      (2),
    .DATA_WIDTH (8),
    .FEEDTHROUGH(1'b1)
  ) dut_b (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .flush_i   (b_fl),
`ifdef HPDCACHE_REFILL_FIFO_PEAK_OCC_EN
    .peak_clr_i(b_pk_clr),
    .peak_occ_o(b_peak),
`endif
    .w_i       (b_w),
    .wok_o     (b_wok),
    .wdata_i   (b_d),
    .r_i       (b_r),
    .rok_o     (b_rok),
    .rdata_o   (b_rdata),
    .occ_o     (b_occ),
    .afull_o   (b_afull)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_fl = 0; a_w = 0; a_r = 0; a_d = '0;
    b_fl = 0; b_w = 0; b_r = 0; b_d = '0;
`ifdef HPDCACHE_REFILL_FIFO_PEAK_OCC_EN
    a_pk_clr = 0; b_pk_clr = 0;
`endif
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_occ, a_afull, a_wok, a_rok} !== {2'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_a: occ/afull/wok/rok got %b, expected 00010",
               {a_occ, a_afull, a_wok, a_rok});
    end
    n_checks++;
    if ({b_occ, b_afull, b_wok, b_rok} !== {2'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_b: occ/afull/wok/rok got %b, expected 00010",
               {b_occ, b_afull, b_wok, b_rok});
    end
`ifdef HPDCACHE_REFILL_FIFO_PEAK_OCC_EN
    n_checks++;
    if ({a_peak, b_peak} !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_peak: got %h, expected 0", {a_peak, b_peak});
    end
`endif
    #11 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [3];
    vals = '{8'hA1, 8'hA2, 8'hA3};
    for (int i = 0; i < 3; i++) begin
      a_w = 1; a_d = vals[i];
      #1;
      n_checks++;
      if (a_wok !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_wok[%0d]: got %b, expected 1", i, a_wok);
      end
      tick();
      a_w = 0;
      #1;
      n_checks++;
      if ({a_occ, a_afull, a_wok, a_rok} !== {2'(i + 1), (i + 1) >= 2, (i + 1) < 3, 1'b1}) begin
        n_fail++;
        $display("FAIL fill_state[%0d]: occ/afull/wok/rok got %b, expected %b", i,
                 {a_occ, a_afull, a_wok, a_rok},
                 {2'(i + 1), (i + 1) >= 2, (i + 1) < 3, 1'b1});
      end
    end
    for (int i = 0; i < 3; i++) begin
      a_r = 1;
      #1;
      n_checks++;
      if ({a_rok, a_rdata} !== {1'b1, vals[i]}) begin
        n_fail++;
        $display("FAIL drain_data[%0d]: rok/rdata got %b/%h, expected 1/%h", i, a_rok, a_rdata,
                 vals[i]);
      end
      tick();
      a_r = 0;
      #1;
      n_checks++;
      if (a_occ !== 2'(2 - i)) begin
        n_fail++;
        $display("FAIL drain_occ[%0d]: got %0d, expected %0d", i, a_occ, 2 - i);
      end
    end
    n_checks++;
    if ({a_rok, a_afull, a_wok} !== 3'b001) begin
      n_fail++;
      $display("FAIL drain_end: rok/afull/wok got %b, expected 001", {a_rok, a_afull, a_wok});
    end
  endtask

  task automatic test_wrap();
    a_w = 1; a_d = 8'h10;
    tick();
    for (int i = 1; i <= 10; i++) begin
      a_w = 1; a_r = 1; a_d = 8'(8'h10 + i);
      #1;
      n_checks++;
      if ({a_rok, a_rdata} !== {1'b1, 8'(8'h10 + i - 1)}) begin
        n_fail++;
        $display("FAIL wrap_data[%0d]: rok/rdata got %b/%h, expected 1/%h", i, a_rok, a_rdata,
                 8'(8'h10 + i - 1));
      end
      tick();
      n_checks++;
      if (a_occ !== 2'd1) begin
        n_fail++;
        $display("FAIL wrap_occ[%0d]: got %0d, expected 1", i, a_occ);
      end
    end
    a_w = 0; a_r = 1;
    #1;
    n_checks++;
    if (a_rdata !== 8'h1A) begin
      n_fail++;
      $display("FAIL wrap_last: got %h, expected 1a", a_rdata);
    end
    tick();
    a_r = 0;
    #1;
    n_checks++;
    if ({a_occ, a_rok} !== 3'b000) begin
      n_fail++;
      $display("FAIL wrap_empty: occ/rok got %b, expected 000", {a_occ, a_rok});
    end
  endtask

  task automatic test_bypass();
    b_w = 1; b_d = 8'h55; b_r = 1;
    #1;
    n_checks++;
    if ({b_rok, b_rdata, b_wok} !== {1'b1, 8'h55, 1'b1}) begin
      n_fail++;
      $display("FAIL bypass_comb: rok/rdata/wok got %b/%h/%b, expected 1/55/1", b_rok, b_rdata,
               b_wok);
    end
    tick();
    b_w = 0; b_r = 0;
    #1;
    n_checks++;
    if ({b_occ, b_rok, b_afull} !== 4'b0000) begin
      n_fail++;
      $display("FAIL bypass_after: occ/rok/afull got %b, expected 0000", {b_occ, b_rok, b_afull});
    end
  endtask

  task automatic test_full_rw();
    b_w = 1; b_d = 8'h11;
    tick();
    b_d = 8'h22;
    tick();
    b_w = 0;
    #1;
    n_checks++;
    if ({b_occ, b_wok, b_afull, b_rdata} !== {2'd2, 1'b0, 1'b1, 8'h11}) begin
      n_fail++;
      $display("FAIL full_state: occ/wok/afull/rdata got %0d/%b/%b/%h, expected 2/0/1/11",
               b_occ, b_wok, b_afull, b_rdata);
    end
    b_w = 1; b_d = 8'h33; b_r = 1;
    #1;
    n_checks++;
    if ({b_wok, b_rok, b_rdata} !== {1'b0, 1'b1, 8'h11}) begin
      n_fail++;
      $display("FAIL full_rw: wok/rok/rdata got %b/%b/%h, expected 0/1/11", b_wok, b_rok,
               b_rdata);
    end
    tick();
    b_w = 0; b_r = 0;
    #1;
    n_checks++;
    if ({b_occ, b_rok, b_rdata} !== {2'd1, 1'b1, 8'h22}) begin
      n_fail++;
      $display("FAIL full_after: occ/rok/rdata got %0d/%b/%h, expected 1/1/22", b_occ, b_rok,
               b_rdata);
    end
    b_r = 1;
    tick();
    b_r = 0;
    #1;
    n_checks++;
    if (b_occ !== 2'd0) begin
      n_fail++;
      $display("FAIL full_drain: occ got %0d, expected 0", b_occ);
    end
  endtask

  task automatic test_flush();
    a_w = 1; a_d = 8'hB1;
    tick();
    a_d = 8'hB2;
    tick();
    a_fl = 1; a_w = 1; a_d = 8'hEE;
    b_fl = 1; b_w = 1; b_d = 8'hEE; b_r = 1;
    #1;
    n_checks++;
    if ({a_rok, a_wok, b_rok, b_wok} !== 4'b0000) begin
      n_fail++;
      $display("FAIL flush_force: a rok/wok, b rok/wok got %b, expected 0000",
               {a_rok, a_wok, b_rok, b_wok});
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if ({a_occ, a_rok, a_afull, b_occ, b_rok} !== 7'd0) begin
      n_fail++;
      $display("FAIL flush_after: a occ/rok/afull, b occ/rok got %b, expected 0000000",
               {a_occ, a_rok, a_afull, b_occ, b_rok});
    end
    a_w = 1; a_d = 8'hC1;
    tick();
    a_w = 0; a_r = 1;
    #1;
    n_checks++;
    if ({a_occ, a_rdata} !== {2'd1, 8'hC1}) begin
      n_fail++;
      $display("FAIL flush_nostale: occ/rdata got %0d/%h, expected 1/c1", a_occ, a_rdata);
    end
    tick();
    a_r = 0;
  endtask

  task automatic test_async_reset();
    a_w = 1; a_d = 8'hD1; b_w = 1; b_d = 8'hD1;
    tick();
    a_d = 8'hD2; b_d = 8'hD2;
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if ({a_occ, b_occ} !== {2'd2, 2'd2}) begin
      n_fail++;
      $display("FAIL areset_pre: occ a/b got %0d/%0d, expected 2/2", a_occ, b_occ);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_occ, a_afull, a_wok, a_rok, b_occ, b_afull, b_wok, b_rok} !== 10'b0001000010) begin
      n_fail++;
      $display("FAIL areset_now: got %b, expected 0001000010",
               {a_occ, a_afull, a_wok, a_rok, b_occ, b_afull, b_wok, b_rok});
    end
`ifdef HPDCACHE_REFILL_FIFO_PEAK_OCC_EN
    n_checks++;
    if ({a_peak, b_peak} !== 4'd0) begin
      n_fail++;
      $display("FAIL areset_peak: got %h, expected 0", {a_peak, b_peak});
    end
`endif
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic       ea_wok, ea_rok, eb_wok, eb_rok, bpush, bpop;
    logic [7:0] eb_data;
`ifdef HPDCACHE_REFILL_FIFO_PEAK_OCC_EN
    int         pk_a;
    pk_a = 0;
`endif
    for (int c = 0; c < 400; c++) begin
      a_w  = 1'($urandom_range(0, 1));
      a_r  = 1'($urandom_range(0, 1));
      a_d  = 8'($urandom);
      a_fl = ($urandom_range(0, 15) == 0);
      b_w  = 1'($urandom_range(0, 1));
      b_r  = 1'($urandom_range(0, 1));
      b_d  = 8'($urandom);
      b_fl = ($urandom_range(0, 15) == 0);
`ifdef HPDCACHE_REFILL_FIFO_PEAK_OCC_EN
      a_pk_clr = (c == 0) || ($urandom_range(0, 31) == 0);
`endif
      #1;
      ea_wok = (qa.size() != 3) && !a_fl;
      ea_rok = (qa.size() != 0) && !a_fl;
      eb_wok = (qb.size() != 2) && !b_fl;
      eb_rok = ((qb.size() != 0) || b_w) && !b_fl;
      eb_data = (qb.size() != 0) ? qb[0] : b_d;
      n_checks++;
      if ({a_wok, a_rok} !== {ea_wok, ea_rok}) begin
        n_fail++;
        $display("FAIL rand_a_flags[%0d]: wok/rok got %b%b, expected %b%b", c, a_wok, a_rok,
                 ea_wok, ea_rok);
      end
      if (ea_rok) begin
        n_checks++;
        if (a_rdata !== qa[0]) begin
          n_fail++;
          $display("FAIL rand_a_data[%0d]: got %h, expected %h", c, a_rdata, qa[0]);
        end
      end
      n_checks++;
      if ({b_wok, b_rok} !== {eb_wok, eb_rok}) begin
        n_fail++;
        $display("FAIL rand_b_flags[%0d]: wok/rok got %b%b, expected %b%b", c, b_wok, b_rok,
                 eb_wok, eb_rok);
      end
      if (eb_rok) begin
        n_checks++;
        if (b_rdata !== eb_data) begin
          n_fail++;
          $display("FAIL rand_b_data[%0d]: got %h, expected %h", c, b_rdata, eb_data);
        end
      end
      // Reference update: a queue per FIFO, flush empties it.
      if (a_fl) begin
        qa.delete();
      end else begin
        if (a_r && ea_rok) void'(qa.pop_front());
        if (a_w && ea_wok) qa.push_back(a_d);
      end
      if (b_fl) begin
        qb.delete();
      end else begin
        bpush = b_w && eb_wok;
        bpop  = b_r && eb_rok;
        if (!(bpop && qb.size() == 0)) begin
          if (bpop) void'(qb.pop_front());
          if (bpush) qb.push_back(b_d);
        end
      end
`ifdef HPDCACHE_REFILL_FIFO_PEAK_OCC_EN
      if (a_pk_clr || qa.size() > pk_a) pk_a = qa.size();
`endif
      tick();
      n_checks++;
      if ({a_occ, a_afull} !== {2'(qa.size()), qa.size() >= 2}) begin
        n_fail++;
        $display("FAIL rand_a_occ[%0d]: occ/afull got %0d/%b, expected %0d/%b", c, a_occ,
                 a_afull, qa.size(), qa.size() >= 2);
      end
      n_checks++;
      if ({b_occ, b_afull} !== {2'(qb.size()), qb.size() >= 1}) begin
        n_fail++;
        $display("FAIL rand_b_occ[%0d]: occ/afull got %0d/%b, expected %0d/%b", c, b_occ,
                 b_afull, qb.size(), qb.size() >= 1);
      end
`ifdef HPDCACHE_REFILL_FIFO_PEAK_OCC_EN
      n_checks++;
      if (a_peak !== 2'(pk_a)) begin
        n_fail++;
        $display("FAIL rand_a_peak[%0d]: got %0d, expected %0d", c, a_peak, pk_a);
      end
`endif
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_bypass();
    test_full_rw();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
